// File: rtl/lc3_mem_port_arbiter_if.sv
// Shared memory-port bundle: three pipeline requesters on one side, the external memory bus on the other.
// The arbiter takes the master view; the pipeline/memory environment takes the slave view.
interface lc3_mem_port_arbiter_if;
    logic [2:0]  req;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic [15:0] addr2;
    logic        wr2;
    logic [15:0] wdata2;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [15:0] rdata;
    logic [2:0]  stall;
    logic        mem_en;
    logic        mem_rw;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rdy;
    logic        err;

    modport master (
        input  req, addr0, addr1, addr2, wr2, wdata2, mem_rdata, mem_rdy,
        output gnt, done, rdata, stall, mem_en, mem_rw, mem_addr, mem_wdata, err
    );

    modport slave (
        output req, addr0, addr1, addr2, wr2, wdata2, mem_rdata, mem_rdy,
        input  gnt, done, rdata, stall, mem_en, mem_rw, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/lc3_mem_port_arbiter.sv
// Fixed-priority (2 > 1 > 0) arbiter for the single LC-3 memory port, with ready handshake,
// per-access timeout, one-cycle done pulses and combinational per-port stall.
module lc3_mem_port_arbiter #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    lc3_mem_port_arbiter_if.master        bus
);
    localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t      r_state, w_state_next;
    logic [2:0]  r_gnt, w_gnt_next;
    logic [2:0]  r_done, w_done_next;
    logic        r_mem_en, w_mem_en_next;
    logic        r_mem_rw, w_mem_rw_next;
    logic [15:0] r_mem_addr, w_mem_addr_next;
    logic [15:0] r_mem_wdata, w_mem_wdata_next;
    logic [15:0] r_rdata, w_rdata_next;
    logic        r_err, w_err_next;
    logic [CW-1:0] r_cnt, w_cnt_next;

    logic [2:0]  w_elig;
    logic        w_cnt_last;
    logic        w_complete;

    // A port whose done pulse is in flight is masked so it cannot be granted back-to-back.
    always_comb begin
        w_elig     = bus.req & ~r_done;
        w_cnt_last = (r_cnt == CW'(MEM_TIMEOUT - 1));
        w_complete = bus.mem_rdy | w_cnt_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_done      <= '0;
            r_mem_en    <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_gnt       <= w_gnt_next;
            r_done      <= w_done_next;
            r_mem_en    <= w_mem_en_next;
            r_mem_rw    <= w_mem_rw_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_rdata     <= w_rdata_next;
            r_err       <= w_err_next;
            r_cnt       <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (|w_elig)    w_state_next = ST_BUSY;
            ST_BUSY: if (w_complete) w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_gnt_next       = r_gnt;
        w_done_next      = '0;
        w_mem_en_next    = r_mem_en;
        w_mem_rw_next    = r_mem_rw;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_rdata_next     = r_rdata;
        w_err_next       = r_err;
        w_cnt_next       = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_elig[2]) begin
                    w_gnt_next       = 3'b100;
                    w_mem_addr_next  = bus.addr2;
                    w_mem_rw_next    = bus.wr2;
                    w_mem_wdata_next = bus.wr2 ? bus.wdata2 : '0;
                end else if (w_elig[1]) begin
                    w_gnt_next       = 3'b010;
                    w_mem_addr_next  = bus.addr1;
                    w_mem_rw_next    = 1'b0;
                    w_mem_wdata_next = '0;
                end else if (w_elig[0]) begin
                    w_gnt_next       = 3'b001;
                    w_mem_addr_next  = bus.addr0;
                    w_mem_rw_next    = 1'b0;
                    w_mem_wdata_next = '0;
                end
                if (|w_elig) begin
                    w_mem_en_next = 1'b1;
                    w_cnt_next    = '0;
                end
            end
            ST_BUSY: begin
                w_cnt_next = r_cnt + 1'b1;
                if (w_complete) begin
                    w_done_next   = r_gnt;
                    w_gnt_next    = '0;
                    w_mem_en_next = 1'b0;
                    // mem_rdy on the last counted cycle still wins over the timeout.
                    if (!r_mem_rw)
                        w_rdata_next = bus.mem_rdy ? bus.mem_rdata : '0;
                    if (!bus.mem_rdy)
                        w_err_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.gnt       = r_gnt;
    assign bus.done      = r_done;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_rw    = r_mem_rw;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.rdata     = r_rdata;
    assign bus.err       = r_err;
    assign bus.stall     = bus.req & ~r_done;
endmodule

// File: tb/tb_lc3_mem_port_arbiter.sv
// Random-traffic bench for lc3_mem_port_arbiter: a transaction-timestamp reference model predicts
// every cycle's grant, done, bus, rdata, err and stall values.
module tb_lc3_mem_port_arbiter;
    localparam int unsigned TO    = 16;
    localparam int unsigned N_CYC = 5000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lc3_mem_port_arbiter_if bus_if ();

    lc3_mem_port_arbiter #(.MEM_TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    // Expected DUT outputs for the current cycle
    logic [2:0]  e_gnt, e_done;
    logic        e_en, e_rw, e_err;
    logic [15:0] e_addr, e_wdata, e_rdata;

    // Current access: port, cycle of its last mem_en, cycle mem_rdy is driven (-1 = never)
    bit          acc_on;
    int          acc_port, acc_last, acc_rdy;

    bit   [2:0]  pend;
    logic [2:0]  req_v, elig;
    logic [15:0] addr_v [3];
    logic [15:0] wdata2_v, mrdata_v;
    logic        wr2_v, rst_v;
    int          k;

    initial begin
        reset            = 1'b1;
        bus_if.req       = '0;
        bus_if.addr0     = '0;
        bus_if.addr1     = '0;
        bus_if.addr2     = '0;
        bus_if.wr2       = 1'b0;
        bus_if.wdata2    = '0;
        bus_if.mem_rdata = '0;
        bus_if.mem_rdy   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        e_gnt = '0; e_done = '0; e_en = 1'b0; e_rw = 1'b0; e_err = 1'b0;
        e_addr = '0; e_wdata = '0; e_rdata = '0;
        acc_on = 1'b0; acc_port = 0; acc_last = 0; acc_rdy = -1;
        pend = '0;

        for (int t = 0; t < int'(N_CYC); t++) begin
            chk("gnt",    16'(bus_if.gnt),    16'(e_gnt));
            chk("done",   16'(bus_if.done),   16'(e_done));
            chk("mem_en", 16'(bus_if.mem_en), 16'(e_en));
            chk("err",    16'(bus_if.err),    16'(e_err));
            chk("rdata",  bus_if.rdata,       e_rdata);
            if (e_en) begin
                chk("mem_addr",  bus_if.mem_addr,     e_addr);
                chk("mem_rw",    16'(bus_if.mem_rw),  16'(e_rw));
                chk("mem_wdata", bus_if.mem_wdata,    e_wdata);
            end

            // Stimulus for this cycle
            rst_v = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 3; i++) begin
                if (e_done[i]) begin
                    req_v[i] = 1'($urandom_range(0, 1));
                    pend[i]  = 1'b0;
                end else if (pend[i]) begin
                    req_v[i] = (acc_on && acc_port == i) ? ($urandom_range(0, 3) != 0) : 1'b1;
                end else begin
                    req_v[i] = ($urandom_range(0, 3) == 0);
                    pend[i]  = req_v[i];
                end
                addr_v[i] = 16'($urandom);
            end
            wr2_v    = 1'($urandom_range(0, 1));
            wdata2_v = 16'($urandom);
            mrdata_v = 16'($urandom);

            reset            = rst_v;
            bus_if.req       = req_v;
            bus_if.addr0     = addr_v[0];
            bus_if.addr1     = addr_v[1];
            bus_if.addr2     = addr_v[2];
            bus_if.wr2       = wr2_v;
            bus_if.wdata2    = wdata2_v;
            bus_if.mem_rdata = mrdata_v;
            bus_if.mem_rdy   = acc_on ? (t == acc_rdy) : 1'($urandom_range(0, 1));
            #1;
            chk("stall", 16'(bus_if.stall), 16'(req_v & ~e_done));

            // Reference model: expected outputs for the next cycle
            elig = req_v & ~e_done;
            if (rst_v) begin
                e_gnt = '0; e_done = '0; e_en = 1'b0; e_rw = 1'b0; e_err = 1'b0;
                e_addr = '0; e_wdata = '0; e_rdata = '0;
                acc_on = 1'b0;
            end else begin
                e_done = '0;
                if (acc_on) begin
                    if (t == acc_last) begin
                        e_done = 3'(1 << acc_port);
                        e_gnt  = '0;
                        e_en   = 1'b0;
                        if (!e_rw) e_rdata = (t == acc_rdy) ? mrdata_v : 16'h0000;
                        if (t != acc_rdy) e_err = 1'b1;
                        acc_on = 1'b0;
                    end
                end else if (elig != 3'b000) begin
                    acc_port = elig[2] ? 2 : (elig[1] ? 1 : 0);
                    e_gnt    = 3'(1 << acc_port);
                    e_en     = 1'b1;
                    e_addr   = addr_v[acc_port];
                    e_rw     = (acc_port == 2) && wr2_v;
                    e_wdata  = e_rw ? wdata2_v : 16'h0000;
                    k        = int'($urandom_range(1, TO + 4));
                    acc_rdy  = (k <= int'(TO)) ? t + k : -1;
                    acc_last = t + ((k <= int'(TO)) ? k : int'(TO));
                    acc_on   = 1'b1;
                end
            end

            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
